dog_scene_ctrl: RTL
===================

// Module: dog_scene_ctrl
// PURPOSE
//  Sequences the hunting dog sprite through its per-round animation: intro walk, jump into
//  the grass, then a pop-up showing a held duck or a laugh. Outputs the sprite position and
//  frame index, which the dog sprite address/compositing logic consumes in place of free-running
//  motion. Driven by game-FSM event pulses; returns completion pulses to the game FSM.
// PARAMETERS
//  X_START    10'd0    walk start X (top-left of 64x64 sprite)
//  X_JUMP     10'd240  X at which walk ends and jump begins
//  X_SHOW     10'd288  X used for pop-up (hold/laugh)
//  Y_WALK     10'd300  walking Y
//  Y_TOP      10'd220  jump apex Y
//  Y_HIDE     10'd360  Y fully behind grass
//  Y_SHOW     10'd280  pop-up apex Y
//  STEP       10'd2    pixels moved per frame tick (X and Y)
//  FRAME_DIV  8        frame ticks per animation-frame change
//  SHOW_TICKS 60       frame ticks held at pop-up apex
// PORTS
//  Clk           in   1   50 MHz system clock
//  Reset_n       in   1   synchronous active-low reset
//  frame_clk     in   1   ~60 Hz vertical-sync frame clock
//  round_start   in   1   1-cycle pulse: begin intro sequence
//  duck_shot     in   1   1-cycle pulse: round result = hit
//  duck_escaped  in   1   1-cycle pulse: round result = miss
//  dog_x         out  10  sprite top-left X
//  dog_y         out  10  sprite top-left Y
//  dog_frame     out  3   0-2 walk, 3 jump, 4 hold duck, 5/6 laugh A/B
//  dog_visible   out  1   dog is drawn
//  dog_busy      out  1   not in IDLE/HIDDEN
//  round_go      out  1   1-cycle pulse: intro finished, ducks may fly
//  result_done   out  1   1-cycle pulse: pop-up finished
// BEHAVIOUR
//  - Reset (Reset_n=0 at Clk edge, any state): state=IDLE, dog_x=X_START, dog_y=Y_WALK,
//    dog_frame=0, dog_visible=0, dog_busy=0, round_go=0, result_done=0, pending cleared,
//    tick/anim counters=0. Overrides any sequence in progress.
//  - tick: frame_clk rising edge, detected through a 2-FF delay/compare; all motion, animation
//    and hold counting advance only on cycles where tick=1.
//  - States: IDLE, WALK, JUMP_UP, JUMP_DOWN, HIDDEN, POP_UP, SHOW, POP_DOWN.
//  - IDLE/HIDDEN + round_start: x<=X_START, y<=Y_WALK, frame 0, -> WALK next cycle.
//    round_start in any other state is ignored.
//  - WALK: x+=STEP per tick; frame cycles 0->1->2->0 every FRAME_DIV ticks; x reaching
//    X_JUMP -> JUMP_UP, frame=3.
//  - JUMP_UP: y-=STEP per tick until Y_TOP -> JUMP_DOWN. JUMP_DOWN: y+=STEP until Y_HIDE ->
//    HIDDEN; round_go pulses on the cycle of entry to HIDDEN.
//  - Clamp rule: all arithmetic 10-bit unsigned; if |target-pos| <= STEP, pos<=target
//    (never overshoot, never wrap). State transition occurs on the tick pos reaches target.
//  - Result capture: duck_shot/duck_escaped latched into a 1-entry pending register
//    (valid + kind) in any non-IDLE state; shot wins if both in same cycle; a second
//    event while pending is valid is dropped. IDLE ignores results.
//  - HIDDEN with pending valid: consume pending, x<=X_SHOW, y<=Y_HIDE, frame=4 (hit) or 5
//    (miss), -> POP_UP. Consumption and a same-cycle new result: new result is latched.
//  - POP_UP: y-=STEP to Y_SHOW -> SHOW. SHOW: hold SHOW_TICKS ticks; miss toggles 5/6 every
//    FRAME_DIV ticks, hit stays 4. -> POP_DOWN: y+=STEP to Y_HIDE -> HIDDEN, result_done
//    pulses on entry.
//  - dog_visible=1 in WALK, JUMP_UP, JUMP_DOWN, POP_UP, SHOW, POP_DOWN; 0 in IDLE, HIDDEN.
//  - All outputs registered; pulses exactly 1 Clk cycle wide.
// TESTING
//  - Reset then round_start -> WALK; after 120 ticks dog_x=240, state JUMP_UP, frame=3.
//  - Continue -> after 40 more ticks y=220; after 70 more y=360, round_go one cycle, visible=0.
//  - HIDDEN + duck_shot -> frame=4, y 360->280 in 40 ticks, held 60 ticks, back to 360 in
//    40 ticks, result_done one cycle.
//  - duck_shot and duck_escaped same cycle during WALK -> pending=hit, pop-up frame=4
//    after intro; escaped alone -> frames alternate 5/6 every 8 ticks in SHOW.
//  - STEP=3 with X_JUMP=10: x 0,3,6,9,10 (clamped), no overshoot.
//  - Reset_n=0 mid-SHOW -> next cycle IDLE, all outputs at reset values; round_start ignored
//    in JUMP_UP.

Source files
------------

// File: rtl/dog_scene_ctrl_if.sv
// Event/sprite bundle between the game FSM (master) and the dog scene controller (slave).
interface dog_scene_ctrl_if;
  logic       round_start;
  logic       duck_shot;
  logic       duck_escaped;
  logic [9:0] dog_x;
  logic [9:0] dog_y;
  logic [2:0] dog_frame;
  logic       dog_visible;
  logic       dog_busy;
  logic       round_go;
  logic       result_done;

  modport master (
    output round_start, duck_shot, duck_escaped,
    input  dog_x, dog_y, dog_frame, dog_visible, dog_busy, round_go, result_done
  );

  modport slave (
    input  round_start, duck_shot, duck_escaped,
    output dog_x, dog_y, dog_frame, dog_visible, dog_busy, round_go, result_done
  );
endinterface

// File: rtl/dog_scene_ctrl.sv
// Hunting-dog sprite sequencer: intro walk, jump into grass, then hit/miss pop-up.
//
//   state     | meaning
//   IDLE      | no round running, dog not drawn
//   WALK      | walking right toward the jump point
//   JUMP_UP   | rising to jump apex
//   JUMP_DOWN | falling behind the grass
//   HIDDEN    | behind grass, waiting for a result or next round
//   POP_UP    | rising to show the result
//   SHOW      | holding at pop-up apex
//   POP_DOWN  | sinking back behind the grass
module dog_scene_ctrl #(
  parameter logic [9:0] X_START    = 10'd0,
  parameter logic [9:0] X_JUMP     = 10'd240,
  parameter logic [9:0] X_SHOW     = 10'd288,
  parameter logic [9:0] Y_WALK     = 10'd300,
  parameter logic [9:0] Y_TOP      = 10'd220,
  parameter logic [9:0] Y_HIDE     = 10'd360,
  parameter logic [9:0] Y_SHOW     = 10'd280,
  parameter logic [9:0] STEP       = 10'd2,
  parameter int         FRAME_DIV  = 8,
  parameter int         SHOW_TICKS = 60
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_clk,
  dog_scene_ctrl_if.slave  bus
);

  localparam int AW = $clog2(FRAME_DIV + 1);
  localparam int HW = $clog2(SHOW_TICKS + 1);
  localparam logic [AW-1:0] ANIM_LOAD = AW'(FRAME_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(SHOW_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE, WALK, JUMP_UP, JUMP_DOWN, HIDDEN, POP_UP, SHOW, POP_DOWN
  } state_t;

  state_t        state;
  logic          fc_q1, fc_q2;
  logic          tick;
  logic [9:0]    x_q, y_q;
  logic [2:0]    frame_q;
  logic          vis_q, busy_q, go_q, done_q;
  logic          pend_v, pend_hit;
  logic [AW-1:0] anim_cnt;
  logic [HW-1:0] hold_cnt;
  logic [9:0]    x_walk, y_top, y_hide, y_show;
  logic          new_evt, take_pend;

  // Move one STEP toward target, landing exactly on it when within a step.
  function automatic logic [9:0] approach(input logic [9:0] pos, input logic [9:0] target);
    logic [9:0] r;
    if (pos > target) r = ((pos - target) <= STEP) ? target : pos - STEP;
    else              r = ((target - pos) <= STEP) ? target : pos + STEP;
    return r;
  endfunction

  assign tick      = fc_q1 & ~fc_q2;
  assign x_walk    = approach(x_q, X_JUMP);
  assign y_top     = approach(y_q, Y_TOP);
  assign y_hide    = approach(y_q, Y_HIDE);
  assign y_show    = approach(y_q, Y_SHOW);
  assign new_evt   = (bus.duck_shot | bus.duck_escaped) && (state != IDLE);
  assign take_pend = (state == HIDDEN) && pend_v && !bus.round_start;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fc_q1    <= 1'b0;
      fc_q2    <= 1'b0;
      state    <= IDLE;
      x_q      <= X_START;
      y_q      <= Y_WALK;
      frame_q  <= 3'd0;
      vis_q    <= 1'b0;
      busy_q   <= 1'b0;
      go_q     <= 1'b0;
      done_q   <= 1'b0;
      pend_v   <= 1'b0;
      pend_hit <= 1'b0;
      anim_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      fc_q1  <= frame_clk;
      fc_q2  <= fc_q1;
      go_q   <= 1'b0;
      done_q <= 1'b0;

      // A result arriving while the slot is being consumed replaces it.
      if (new_evt && (!pend_v || take_pend)) begin
        pend_v   <= 1'b1;
        pend_hit <= bus.duck_shot;
      end else if (take_pend) begin
        pend_v <= 1'b0;
      end

      case (state)
        IDLE, HIDDEN: begin
          if (bus.round_start) begin
            x_q      <= X_START;
            y_q      <= Y_WALK;
            frame_q  <= 3'd0;
            anim_cnt <= ANIM_LOAD;
            vis_q    <= 1'b1;
            busy_q   <= 1'b1;
            state    <= WALK;
          end else if (take_pend) begin
            x_q     <= X_SHOW;
            y_q     <= Y_HIDE;
            frame_q <= pend_hit ? 3'd4 : 3'd5;
            vis_q   <= 1'b1;
            busy_q  <= 1'b1;
            state   <= POP_UP;
          end
        end
        WALK: if (tick) begin
          x_q <= x_walk;
          if (x_walk == X_JUMP) begin
            frame_q <= 3'd3;
            state   <= JUMP_UP;
          end else if (anim_cnt == '0) begin
            anim_cnt <= ANIM_LOAD;
            frame_q  <= (frame_q == 3'd2) ? 3'd0 : frame_q + 3'd1;
          end else begin
            anim_cnt <= anim_cnt - 1'b1;
          end
        end
        JUMP_UP: if (tick) begin
          y_q <= y_top;
          if (y_top == Y_TOP) state <= JUMP_DOWN;
        end
        JUMP_DOWN: if (tick) begin
          y_q <= y_hide;
          if (y_hide == Y_HIDE) begin
            vis_q  <= 1'b0;
            busy_q <= 1'b0;
            go_q   <= 1'b1;
            state  <= HIDDEN;
          end
        end
        POP_UP: if (tick) begin
          y_q <= y_show;
          if (y_show == Y_SHOW) begin
            anim_cnt <= ANIM_LOAD;
            hold_cnt <= HOLD_LOAD;
            state    <= SHOW;
          end
        end
        SHOW: if (tick) begin
          if (hold_cnt == '0) begin
            state <= POP_DOWN;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
            if (anim_cnt == '0) begin
              anim_cnt <= ANIM_LOAD;
              // hit frame (4) holds still; laugh alternates A/B
              if (frame_q != 3'd4) frame_q <= (frame_q == 3'd5) ? 3'd6 : 3'd5;
            end else begin
              anim_cnt <= anim_cnt - 1'b1;
            end
          end
        end
        POP_DOWN: if (tick) begin
          y_q <= y_hide;
          if (y_hide == Y_HIDE) begin
            vis_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= HIDDEN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dog_x       = x_q;
  assign bus.dog_y       = y_q;
  assign bus.dog_frame   = frame_q;
  assign bus.dog_visible = vis_q;
  assign bus.dog_busy    = busy_q;
  assign bus.round_go    = go_q;
  assign bus.result_done = done_q;

endmodule
